// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM sequencing one instruction over 2-5 cycles
// Ports: clk, rst (async, active-high), opcode (IR[31:26]), mem_ready (memory done, MC_WAIT_EN only);
// datapath controls pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite, regDst,
// memtoReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource; debug state; illegal-opcode pulse.
// Build option: define MC_WAIT_EN to hold FETCH/MEM_READ/MEM_WRITE until mem_ready=1.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       branchNe,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memtoReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic [3:0] state,
  output logic       illegal
);
  localparam logic [5:0] OP_R = 6'b000000, OP_I = 6'b000001, OP_LW = 6'b100010, OP_LWI = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101010, OP_BEQ = 6'b000100, OP_BNE = 6'b000110, OP_J = 6'b010000;
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_READ = 4'd4, MEM_WB = 4'd5,
    MEM_WRITE = 4'd6, R_EXEC = 4'd7, I_EXEC = 4'd8, ALU_WB = 4'd9, IMM_WB = 4'd10,
    BRANCH = 4'd11, JUMP = 4'd12
  } state_t;
  state_t st, nx;
  logic [5:0] op_q;
  logic armed, done, is_mem, is_br, legal;
`ifdef MC_WAIT_EN
  assign done = mem_ready;
`else
  logic unused;
  assign unused = mem_ready;
  assign done = 1'b1;
`endif
  assign state = st;
  assign is_mem = opcode == OP_LW || opcode == OP_LWI || opcode == OP_SW;
  assign is_br = opcode == OP_BEQ || opcode == OP_BNE;
  assign legal = opcode == OP_R || opcode == OP_I || is_mem || is_br || opcode == OP_J;
  // armed delays the first FETCH to the second edge after reset release
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      armed <= 1'b0;
      op_q <= '0;
      illegal <= 1'b0;
    end else begin
      st <= nx;
      armed <= 1'b1;
      if (st == DECODE) op_q <= opcode;
      illegal <= st == DECODE && !legal;
    end
  always_comb begin
    nx = FETCH;
    case (st)
      IDLE:      nx = armed ? FETCH : IDLE;
      FETCH:     nx = done ? DECODE : FETCH;
      DECODE:    nx = opcode == OP_R ? R_EXEC : opcode == OP_I ? I_EXEC : is_mem ? MEM_ADDR :
                      is_br ? BRANCH : opcode == OP_J ? JUMP : FETCH;
      MEM_ADDR:  nx = op_q == OP_LW ? MEM_READ : op_q == OP_SW ? MEM_WRITE : IMM_WB;
      MEM_READ:  nx = done ? MEM_WB : MEM_READ;
      MEM_WRITE: nx = done ? FETCH : MEM_WRITE;
      R_EXEC:    nx = ALU_WB;
      I_EXEC:    nx = ALU_WB;
      default:   nx = FETCH;
    endcase
  end
  always_comb begin
    pcWrite = 1'b0;
    pcWriteCond = 1'b0;
    branchNe = 1'b0;
    iorD = 1'b0;
    memRead = 1'b0;
    memWrite = 1'b0;
    irWrite = 1'b0;
    regDst = 1'b0;
    memtoReg = 1'b0;
    regWrite = 1'b0;
    aluSrcA = 1'b0;
    aluSrcB = 2'b00;
    aluOp = 2'b00;
    pcSource = 2'b00;
    case (st)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        aluOp = 2'b11;
        irWrite = done;
        pcWrite = done;
      end
      DECODE: begin
        aluSrcB = 2'b11;
        aluOp = 2'b11;
      end
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        aluOp = 2'b11;
      end
      MEM_READ: begin
        memRead = 1'b1;
        iorD = 1'b1;
      end
      MEM_WB: begin
        memtoReg = 1'b1;
        regWrite = 1'b1;
      end
      MEM_WRITE: begin
        memWrite = 1'b1;
        iorD = 1'b1;
      end
      R_EXEC:    aluSrcA = 1'b1;
      I_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      ALU_WB: begin
        regDst = 1'b1;
        regWrite = 1'b1;
      end
      IMM_WB:    regWrite = 1'b1;
      BRANCH: begin
        aluSrcA = 1'b1;
        pcWriteCond = 1'b1;
        pcSource = 2'b01;
        branchNe = op_q == OP_BNE;
        aluOp = op_q == OP_BNE ? 2'b01 : 2'b11;
      end
      JUMP: begin
        pcWrite = 1'b1;
        pcSource = 2'b10;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized scoreboard bench for multicycle_control
module tb_multicycle_control;
`ifdef MC_WAIT_EN
  localparam bit W = 1'b1;
`else
  localparam bit W = 1'b0;
`endif
  typedef struct packed {
    logic [3:0] st;
    logic pw, pwc, bne, iord, mrd, mwr, irw, rd, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic ill;
  } exp_t;
  logic clk = 0, rst = 1, mem_ready = 0;
  logic [5:0] opcode = 0;
  logic pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA, illegal;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;
  exp_t q[$];
  int tests = 0, fails = 0, cycle = 0;
  bit ill_pend = 0;
  int force_wait = -1;
  logic [5:0] ops [8] = '{6'b000000, 6'b000001, 6'b100010, 6'b100011, 6'b101010, 6'b000100, 6'b000110, 6'b010000};
  multicycle_control dut (.clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .pcWrite(pcWrite),
    .pcWriteCond(pcWriteCond), .branchNe(branchNe), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regDst(regDst), .memtoReg(memtoReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource), .state(state), .illegal(illegal));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end
  always @(negedge clk) begin
    exp_t a, e;
    cycle++;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {state, pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite, regDst, memtoReg,
           regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegal};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle%0d outputs: got st=%0d vec=%h, want st=%0d vec=%h", cycle, a.st, a, e.st, e);
      end
    end
  end
  task automatic cyc(input exp_t e, input logic [5:0] op, input logic mr);
    opcode = op;
    mem_ready = mr;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  function automatic bit pick_ready(input int k);
    if (force_wait >= 0) return k >= force_wait;
    return W ? ($urandom_range(0, 2) != 0) : 1'($urandom);
  endfunction
  task automatic fetch_dec(input logic [5:0] op);
    exp_t e;
    bit mr, done;
    int k = 0;
    do begin
      mr = pick_ready(k);
      done = W ? mr : 1'b1;
      e = '0;
      e.st = 1; e.mrd = 1; e.asb = 2'b01; e.aop = 2'b11; e.irw = done; e.pw = done; e.ill = ill_pend;
      ill_pend = 0;
      cyc(e, 6'($urandom), mr);
      k++;
    end while (!done);
    e = '0;
    e.st = 2; e.asb = 2'b11; e.aop = 2'b11;
    cyc(e, op, 1'($urandom));
  endtask
  task automatic mem_state(input logic [3:0] s, input bit wr);
    exp_t e;
    bit mr, done;
    int k = 0;
    do begin
      mr = pick_ready(k);
      done = W ? mr : 1'b1;
      e = '0;
      e.st = s; e.iord = 1; e.mwr = wr; e.mrd = !wr;
      cyc(e, 6'($urandom), mr);
      k++;
    end while (!done);
  endtask
  task automatic addr_phase();
    exp_t e = '0;
    e.st = 3; e.asa = 1; e.asb = 2'b10; e.aop = 2'b11;
    cyc(e, 6'($urandom), 1'($urandom));
  endtask
  task automatic simple(input logic [3:0] s, input bit pw, pwc, bne, rd, m2r, rw, asa,
                        input logic [1:0] asb, aop, psrc);
    exp_t e = '0;
    e.st = s; e.pw = pw; e.pwc = pwc; e.bne = bne; e.rd = rd; e.m2r = m2r; e.rw = rw; e.asa = asa;
    e.asb = asb; e.aop = aop; e.psrc = psrc;
    cyc(e, 6'($urandom), 1'($urandom));
  endtask
  task automatic instr(input logic [5:0] op);
    fetch_dec(op);
    case (op)
      6'b000000: begin simple(7, 0,0,0, 0,0,0, 1, 2'b00, 2'b00, 2'b00); simple(9, 0,0,0, 1,0,1, 0, 0, 0, 0); end
      6'b000001: begin simple(8, 0,0,0, 0,0,0, 1, 2'b10, 2'b00, 2'b00); simple(9, 0,0,0, 1,0,1, 0, 0, 0, 0); end
      6'b100010: begin addr_phase(); mem_state(4, 0); simple(5, 0,0,0, 0,1,1, 0, 0, 0, 0); end
      6'b100011: begin addr_phase(); simple(10, 0,0,0, 0,0,1, 0, 0, 0, 0); end
      6'b101010: begin addr_phase(); mem_state(6, 1); end
      6'b000100: simple(11, 0,1,0, 0,0,0, 1, 2'b00, 2'b11, 2'b01);
      6'b000110: simple(11, 0,1,1, 0,0,0, 1, 2'b00, 2'b01, 2'b01);
      6'b010000: simple(12, 1,0,0, 0,0,0, 0, 2'b00, 2'b00, 2'b10);
      default:   ill_pend = 1;
    endcase
  endtask
  function automatic logic [5:0] rand_op();
    logic [5:0] o;
    if ($urandom_range(0, 5) != 0) return ops[$urandom_range(0, 7)];
    o = 6'($urandom);
    return o;
  endfunction
  task automatic reset_release();
    exp_t e = '0;
    cyc(e, 6'($urandom), 1'($urandom));
    rst = 0;
    cyc(e, 6'($urandom), 1'($urandom));
    cyc(e, 6'($urandom), 1'($urandom));
    ill_pend = 0;
  endtask
  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    reset_release();
    instr(6'b100010);
    instr(6'b000110);
    instr(6'b000100);
    instr(6'b111111);
    instr(6'b000000);
    instr(6'b010000);
    instr(6'b100011);
    instr(6'b000001);
    force_wait = 3;
    instr(6'b101010);
    force_wait = -1;
    for (int i = 0; i < 300; i++) instr(rand_op());
    fetch_dec(6'b101010);
    addr_phase();
    opcode = 6'($urandom);
    mem_ready = 0;
    e = '0;
    e.st = 6; e.iord = 1; e.mwr = 1;
    q.push_back(e);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    tests++;
    if (state !== 4'd0 || memWrite !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got state=%0d memWrite=%b, want state=0 memWrite=0", state, memWrite);
    end
    @(posedge clk);
    #1;
    reset_release();
    for (int i = 0; i < 50; i++) instr(rand_op());
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
